// File: rtl/piso_pkg.sv
// piso_pkg: shared state type and sizing helpers for the PISO serializer.
// Build option: define PISO_PARITY_EN to append an even-parity beat after
// the data bits of every word.
package piso_pkg;

  // Two-state serializer FSM: waiting for a word, or streaming one out.
  typedef enum logic {IDLE, SHIFT} piso_state_t;

`ifdef PISO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Beats per word: the data bits, plus one parity beat when enabled.
  function automatic int calc_nbeats(input int data_width);
    return PARITY_EN ? data_width + 1 : data_width;
  endfunction

  // Counter width large enough to hold NBEATS, so NBEATS-1 never wraps.
  function automatic int calc_cnt_width(input int data_width);
    return $clog2(calc_nbeats(data_width) + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake plus serial valid/ready stream.
// The slave modport is the serializer; the master modport is whoever feeds
// the parallel word and consumes the serial beats.
interface piso_serializer_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  ser_out;
  logic                  ser_valid;
  logic                  ser_last;
  logic                  ser_ready;
  logic                  busy;

  modport master (
    output load_valid,
    output load_data,
    output ser_ready,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_last,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  ser_ready,
    output load_ready,
    output ser_out,
    output ser_valid,
    output ser_last,
    output busy
  );

endinterface

// File: rtl/piso_beat_counter.sv
// piso_beat_counter: counts transferred beats within one word.
// clear restarts the count (new word loaded or word finished); inc advances
// it on each accepted beat. is_last flags the final beat of the word.
module piso_beat_counter #(
  parameter int NBEATS = 8,
  parameter int CNT_W  = $clog2(NBEATS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             is_last
);

  assign is_last = (count == CNT_W'(NBEATS - 1));

  // Beat index register; saturates at the last beat so it can never run past it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !is_last) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage with valid/ready on both
// sides. A word is captured on the load handshake and sent one bit per beat,
// MSB or LSB first. The load port reopens combinationally on the last-beat
// transfer so consecutive words stream with no idle cycle.
// Build option: PISO_PARITY_EN adds a trailing even-parity beat per word.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic               clk,
  input logic               reset,
  piso_serializer_if.slave  io
);

  localparam int NBEATS = calc_nbeats(DATA_WIDTH);
  localparam int CNT_W  = calc_cnt_width(DATA_WIDTH);

  piso_state_t           state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_shifted;
  logic                  ser_valid_q;
  logic                  ser_last_q;
  logic                  busy_q;
  logic [CNT_W-1:0]      cnt;
  logic                  is_last;
  logic                  beat_fire;
  logic                  last_fire;
  logic                  load_ready_c;
  logic                  load_fire;
  logic                  data_bit;

  assign beat_fire    = ser_valid_q && io.ser_ready;
  assign last_fire    = beat_fire && is_last;
  assign load_ready_c = reset && ((state == IDLE) || last_fire);
  assign load_fire    = io.load_valid && load_ready_c;

  // Output end and shift direction depend on the configured bit order.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted = {shreg[DATA_WIDTH-2:0], 1'b0};
      assign data_bit      = shreg[DATA_WIDTH-1];
    end else begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg[DATA_WIDTH-1:1]};
      assign data_bit      = shreg[0];
    end
  endgenerate

  piso_beat_counter #(
    .NBEATS (NBEATS),
    .CNT_W  (CNT_W)
  ) u_beat_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (load_fire || last_fire),
    .inc     (beat_fire),
    .count   (cnt),
    .is_last (is_last)
  );

`ifdef PISO_PARITY_EN
  logic parity_q;

  // Capture even parity of the word at load time so load_data is never re-sampled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (load_fire) begin
      parity_q <= ^io.load_data;
    end
  end

  // By the parity beat the data bits have all been shifted out.
  assign io.ser_out = ser_last_q ? parity_q : data_bit;
`else
  assign io.ser_out = data_bit;
`endif

  assign io.load_ready = load_ready_c;
  assign io.ser_valid  = ser_valid_q;
  assign io.ser_last   = ser_last_q;
  assign io.busy       = busy_q;

  // Serializer FSM: load, shift on each accepted beat, reload or idle after the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_fire) begin
            state       <= SHIFT;
            shreg       <= io.load_data;
            ser_valid_q <= 1'b1;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        SHIFT: begin
          if (load_fire) begin
            shreg      <= io.load_data;
            ser_last_q <= 1'b0;
          end else if (last_fire) begin
            state       <= IDLE;
            shreg       <= shreg_shifted;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            busy_q      <= 1'b0;
          end else if (beat_fire) begin
            shreg      <= shreg_shifted;
            ser_last_q <= (cnt == CNT_W'(NBEATS - 2));
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: drives an MSB-first and an LSB-first serializer with
// identical stimulus. A transaction-level queue model predicts every output
// each cycle; a vector table and directed sequences pin down exact streams.
module tb_piso_serializer;

  localparam int DW = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif

  logic clk = 1'b0;
  logic reset;

  piso_serializer_if #(.DATA_WIDTH(DW)) bus_msb ();
  piso_serializer_if #(.DATA_WIDTH(DW)) bus_lsb ();

  piso_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b1)) dut_msb (
    .clk   (clk),
    .reset (reset),
    .io    (bus_msb)
  );

  piso_serializer #(.DATA_WIDTH(DW), .MSB_FIRST(1'b0)) dut_lsb (
    .clk   (clk),
    .reset (reset),
    .io    (bus_lsb)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic msb_bit;
    logic lsb_bit;
    logic last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] msb_seq;
    logic [DW-1:0] lsb_seq;
    logic          parity;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[8];
  int    checks = 0;
  int    errors = 0;

  logic obs_valid_m, obs_out_m, obs_last_m, obs_ready_m, obs_xfer_m, obs_load_m;
  logic obs_out_l;

  // Bounded run time: any hang is reported and stopped.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, want %0b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_val(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expand a word into its beats in both bit orders, with parity if built in.
  function automatic void push_word(input logic [DW-1:0] d);
    beat_t b;
    int    ones = 0;
    for (int i = 0; i < DW; i++) begin
      b.msb_bit = d[DW-1-i];
      b.lsb_bit = d[i];
      b.last    = (i == NB - 1);
      exp_q.push_back(b);
      if (d[i]) ones++;
    end
    if (NB > DW) begin
      b.msb_bit = ((ones % 2) == 1);
      b.lsb_bit = ((ones % 2) == 1);
      b.last    = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic model_ready();
    if (!reset) return 1'b0;
    if (exp_q.size() == 0) return 1'b1;
    return exp_q[0].last && bus_msb.ser_ready;
  endfunction

  task automatic apply_stimulus(input logic lv, input logic [DW-1:0] ld, input logic sr);
    bus_msb.load_valid = lv;
    bus_msb.load_data  = ld;
    bus_msb.ser_ready  = sr;
    bus_lsb.load_valid = lv;
    bus_lsb.load_data  = ld;
    bus_lsb.ser_ready  = sr;
  endtask

  task automatic check_output();
    logic e_valid, e_m, e_l, e_last, e_ready;
    e_valid = (exp_q.size() > 0);
    e_m     = 1'b0;
    e_l     = 1'b0;
    e_last  = 1'b0;
    if (e_valid) begin
      e_m    = exp_q[0].msb_bit;
      e_l    = exp_q[0].lsb_bit;
      e_last = exp_q[0].last;
    end
    e_ready = model_ready();
    check_bit("msb.ser_valid",  bus_msb.ser_valid,  e_valid);
    check_bit("msb.ser_out",    bus_msb.ser_out,    e_m);
    check_bit("msb.ser_last",   bus_msb.ser_last,   e_last);
    check_bit("msb.busy",       bus_msb.busy,       e_valid);
    check_bit("msb.load_ready", bus_msb.load_ready, e_ready);
    check_bit("lsb.ser_valid",  bus_lsb.ser_valid,  e_valid);
    check_bit("lsb.ser_out",    bus_lsb.ser_out,    e_l);
    check_bit("lsb.ser_last",   bus_lsb.ser_last,   e_last);
    check_bit("lsb.busy",       bus_lsb.busy,       e_valid);
    check_bit("lsb.load_ready", bus_lsb.load_ready, e_ready);
  endtask

  // One clock: check outputs mid-cycle, record what the DUT did, advance the model.
  task automatic cycle();
    logic e_ready;
    #1;
    check_output();
    obs_valid_m = bus_msb.ser_valid;
    obs_out_m   = bus_msb.ser_out;
    obs_last_m  = bus_msb.ser_last;
    obs_ready_m = bus_msb.load_ready;
    obs_xfer_m  = bus_msb.ser_valid && bus_msb.ser_ready;
    obs_load_m  = bus_msb.load_valid && bus_msb.load_ready;
    obs_out_l   = bus_lsb.ser_out;
    if (reset) begin
      e_ready = model_ready();
      if (exp_q.size() > 0 && bus_msb.ser_ready) void'(exp_q.pop_front());
      if (bus_msb.load_valid && e_ready) push_word(bus_msb.load_data);
    end
    @(negedge clk);
  endtask

  // Load one word at full rate and compare the observed streams to the table.
  task automatic run_vector(input vec_t v);
    int            n;
    int            last_at;
    logic          done;
    logic [DW-1:0] seq_m;
    logic [DW-1:0] seq_l;
    logic          par_m;
    logic          par_l;
    n       = 0;
    last_at = -1;
    done    = 1'b0;
    seq_m   = '0;
    seq_l   = '0;
    par_m   = 1'b0;
    par_l   = 1'b0;
    apply_stimulus(1'b1, v.data, 1'b1);
    cycle();
    apply_stimulus(1'b0, '0, 1'b1);
    for (int c = 0; c < NB + 4 && !done; c++) begin
      cycle();
      if (obs_xfer_m) begin
        if (n < DW) begin
          seq_m[n] = obs_out_m;
          seq_l[n] = obs_out_l;
        end else begin
          par_m = obs_out_m;
          par_l = obs_out_l;
        end
        if (obs_last_m) begin
          done    = 1'b1;
          last_at = n;
        end
        n++;
      end
    end
    check_val("vec.beats", n, NB);
    check_val("vec.last_index", last_at, NB - 1);
    check_val("vec.msb_stream", int'(seq_m), int'(v.msb_seq));
    check_val("vec.lsb_stream", int'(seq_l), int'(v.lsb_seq));
`ifdef PISO_PARITY_EN
    check_bit("vec.msb_parity", par_m, v.parity);
    check_bit("vec.lsb_parity", par_l, v.parity);
`endif
    cycle();
  endtask

  initial begin
    int            n;
    int            run;
    int            ones;
    int            pulses;
    logic          done;
    logic [DW-1:0] data;
    logic [DW-1:0] seq_m;

    vecs[0] = '{data: 8'hA5, msb_seq: 8'hA5, lsb_seq: 8'hA5, parity: 1'b0};
    vecs[1] = '{data: 8'h01, msb_seq: 8'h80, lsb_seq: 8'h01, parity: 1'b1};
    vecs[2] = '{data: 8'hC3, msb_seq: 8'hC3, lsb_seq: 8'hC3, parity: 1'b0};
    vecs[3] = '{data: 8'h07, msb_seq: 8'hE0, lsb_seq: 8'h07, parity: 1'b1};
    vecs[4] = '{data: 8'h03, msb_seq: 8'hC0, lsb_seq: 8'h03, parity: 1'b0};
    vecs[5] = '{data: 8'h2C, msb_seq: 8'h34, lsb_seq: 8'h2C, parity: 1'b1};
    vecs[6] = '{data: 8'h5A, msb_seq: 8'h5A, lsb_seq: 8'h5A, parity: 1'b0};
    vecs[7] = '{data: 8'h81, msb_seq: 8'h81, lsb_seq: 8'h81, parity: 1'b0};

    reset = 1'b1;
    apply_stimulus(1'b0, '0, 1'b1);
    #1 reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset held for three cycles");
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(1'b1, 8'hFF, 1'b1);
      cycle();
    end
    apply_stimulus(1'b0, '0, 1'b1);
    reset = 1'b1;
    cycle();

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) run_vector(vecs[i]);

    $display("[TB] backpressure after beat two");
    data  = 8'hC3;
    n     = 0;
    seq_m = '0;
    apply_stimulus(1'b1, data, 1'b1);
    cycle();
    apply_stimulus(1'b0, '0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      cycle();
      if (obs_xfer_m) begin
        seq_m[n] = obs_out_m;
        n++;
      end
    end
    apply_stimulus(1'b0, '0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check_bit("stall.valid", obs_valid_m, 1'b1);
      check_bit("stall.out", obs_out_m, data[DW-3]);
      check_bit("stall.last", obs_last_m, 1'b0);
    end
    apply_stimulus(1'b0, '0, 1'b1);
    done = 1'b0;
    for (int c = 0; c < NB + 4 && !done; c++) begin
      cycle();
      if (obs_xfer_m) begin
        if (n < DW) seq_m[n] = obs_out_m;
        if (obs_last_m) done = 1'b1;
        n++;
      end
    end
    check_val("stall.beats", n, NB);
    check_val("stall.stream", int'(seq_m), 32'hC3);
    cycle();

    $display("[TB] back-to-back words");
    run    = 0;
    ones   = 0;
    pulses = 0;
    done   = 1'b0;
    apply_stimulus(1'b1, 8'hFF, 1'b1);
    cycle();
    apply_stimulus(1'b1, 8'h00, 1'b1);
    for (int c = 0; c < 3 * NB && !done; c++) begin
      cycle();
      if (obs_valid_m && obs_ready_m) begin
        pulses++;
        apply_stimulus(1'b0, '0, 1'b1);
      end
      if (obs_xfer_m) begin
        run++;
        if (obs_out_m) ones++;
      end else begin
        done = 1'b1;
      end
    end
    check_val("b2b.run", run, 2 * NB);
    check_val("b2b.ones", ones, DW);
    check_val("b2b.ready_pulses", pulses, 2);

    $display("[TB] reset in the middle of a word");
    apply_stimulus(1'b1, 8'h5A, 1'b1);
    cycle();
    apply_stimulus(1'b0, '0, 1'b1);
    for (int c = 0; c < 3; c++) cycle();
    #2 reset = 1'b0;
    #1;
    check_bit("midrst.msb_valid", bus_msb.ser_valid, 1'b0);
    check_bit("midrst.msb_busy", bus_msb.busy, 1'b0);
    check_bit("midrst.lsb_valid", bus_lsb.ser_valid, 1'b0);
    check_bit("midrst.load_ready", bus_msb.load_ready, 1'b0);
    exp_q.delete();
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    run_vector(vecs[7]);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 600; c++) begin
      apply_stimulus(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) != 0));
      cycle();
    end
    apply_stimulus(1'b0, '0, 1'b1);
    for (int c = 0; c < 2 * NB + 2; c++) cycle();
    check_val("drain.queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
